id_ex_stage: RTL

- ID/EX pipeline register for the 5-stage MIPS core; sits directly downstream of the main control decoder and register file.
- Latches the decoded control bundle, operands and register specifiers into EX each cycle.
- Detects load-use hazards and inserts one bubble while stalling upstream.
- Honours the debug unit's step enable and the branch-resolution flush, and raises a sticky halt when End-of-Program reaches EX.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core pipeline.
// Holds the decoded control bundle layout (LSB first), its width, the bubble
// encoding, per-field bit indices, and a helper that tells whether an
// instruction reads rt as a source operand.
package cpu_pkg;

    localparam int CTRL_W = 21;

    // Field bit positions inside the packed control bundle
    localparam int REGDST_BIT        = 0;
    localparam int BRANCH_BIT        = 1;
    localparam int BRANCH_TYPE_BIT   = 2;
    localparam int JUMP_BIT          = 3;
    localparam int MEM_TO_REG_BIT    = 4;
    localparam int MEM_WRITE_LO      = 5;
    localparam int MEM_WRITE_HI      = 8;
    localparam int ALU_SRC_BIT       = 9;
    localparam int ALU_SHIFT_IMM_BIT = 10;
    localparam int REG_WRITE_BIT     = 11;
    localparam int LOAD_IMM_BIT      = 12;
    localparam int ZERO_EX_BIT       = 13;
    localparam int EOP_BIT           = 14;
    localparam int MEM_RD_W_LO       = 15;
    localparam int MEM_RD_W_HI       = 16;
    localparam int ALU_CTRL_LO       = 17;
    localparam int ALU_CTRL_HI       = 20;

    // Declared MSB first so the packed layout matches the bit indices above
    typedef struct packed {
        logic [3:0] alu_control;
        logic [1:0] mem_read_width;
        logic       eop;
        logic       zero_ex;
        logic       load_imm;
        logic       reg_write;
        logic       alu_shift_imm;
        logic       alu_src;
        logic [3:0] mem_write;
        logic       mem_to_reg;
        logic       jump;
        logic       branch_type;
        logic       branch;
        logic       regdst;
    } ctrlBundle_t;

    // All-zero bundle: no register write, no memory write, no EOP
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    // rt is a source for R-type ops, stores (data) and compare-branches.
    // Jumps that happen to set the branch bit do not read rt.
    function automatic logic usesRt(input logic regDst, input logic [3:0] memWrite,
                                    input logic branch, input logic jump);
        return regDst | (|memWrite) | (branch & ~jump);
    endfunction

endpackage

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   en                  debug-unit advance enable; 0 freezes every register
//   flush               taken branch/jump; instruction in ID is discarded
//   id_ctrl, id_*       decoded control bundle, operands and fields from ID
//   ex_ctrl, ex_*       registered copies presented to EX
//   stall               combinational; upstream holds PC and IF/ID
//   halted              sticky, set once an EOP instruction leaves EX
//   bubble_cnt          saturating count of load-use bubbles inserted
//
// hazard_unit is kept here as a standalone combinational block so a later
// forwarding unit can reuse it without pulling in the pipeline register.

module hazard_unit
    import cpu_pkg::*;
(
    input  logic       exMemToReg,
    input  logic [4:0] exRt,
    input  logic       idRegDst,
    input  logic [3:0] idMemWrite,
    input  logic       idBranch,
    input  logic       idJump,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       en,
    input  logic       flush,
    input  logic       halted,
    output logic       loadUse,
    output logic       stall
);

    logic rtIsSource;

    always_comb begin
        rtIsSource = usesRt(idRegDst, idMemWrite, idBranch, idJump);
        // r0 is hardwired to zero, so a load into it never creates a dependency
        loadUse    = exMemToReg & (exRt != 5'd0) &
                     ((exRt == idRs) | (rtIsSource & (exRt == idRt)));
        // A flush or halt replaces the ID instruction anyway, so holding it is pointless
        stall      = loadUse & en & ~flush & ~halted;
    end

endmodule

module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic              stall,
    output logic              halted,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ctrlBundle_t idCtrlS;
    ctrlBundle_t exCtrlS;
    logic        loadUse;

    assign idCtrlS = ctrlBundle_t'(id_ctrl);
    assign exCtrlS = ctrlBundle_t'(ex_ctrl);

    hazard_unit uHazard (
        .exMemToReg (exCtrlS.mem_to_reg),
        .exRt       (ex_rt),
        .idRegDst   (idCtrlS.regdst),
        .idMemWrite (idCtrlS.mem_write),
        .idBranch   (idCtrlS.branch),
        .idJump     (idCtrlS.jump),
        .idRs       (id_rs),
        .idRt       (id_rt),
        .en         (en),
        .flush      (flush),
        .halted     (halted),
        .loadUse    (loadUse),
        .stall      (stall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl     <= CTRL_BUBBLE;
            ex_pc_plus4 <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_shamt    <= '0;
            halted      <= 1'b0;
            bubble_cnt  <= '0;
        end else if (en) begin
            // The EOP instruction still moves on this edge; halt takes effect next
            if (exCtrlS.eop)
                halted <= 1'b1;

            if (halted || flush || loadUse) begin
                ex_ctrl     <= CTRL_BUBBLE;
                ex_pc_plus4 <= '0;
                ex_rdata1   <= '0;
                ex_rdata2   <= '0;
                ex_imm      <= '0;
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_rd       <= '0;
                ex_shamt    <= '0;
                // Only genuine load-use bubbles are counted (not flush/halt ones)
                if (!halted && !flush && (bubble_cnt != '1))
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
            end else begin
                ex_ctrl     <= id_ctrl;
                ex_pc_plus4 <= id_pc_plus4;
                ex_rdata1   <= id_rdata1;
                ex_rdata2   <= id_rdata2;
                ex_imm      <= id_imm;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_rd       <= id_rd;
                ex_shamt    <= id_shamt;
            end
        end
    end

endmodule
